ctrl_sequencer: RTL and testbench

//  Hardwired control unit for the Mini SRC datapath: replaces hand-driven testbench control FSMs.

---
 rtl/ctrl_sequencer_pkg.sv | 47 ++++
 rtl/ctrl_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared Mini SRC encodings: opcodes, bus source codes, ALU codes, sequencer states.
// Imported by the sequencer, the datapath and the benches so every party agrees on the codes.
package ctrl_sequencer_pkg;

  localparam int OPW_C  = 5;
  localparam int ALUW_C = 4;
  localparam int BSW_C  = 5;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] BUS_GP     = 5'b00000;
  localparam logic [4:0] BUS_ZLO    = 5'b10011;
  localparam logic [4:0] BUS_PC     = 5'b10100;
  localparam logic [4:0] BUS_MDR    = 5'b10101;
  localparam logic [4:0] BUS_INPORT = 5'b10110;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;

  // ldi shares the ALU_T4 strobes only through ALU_ADD; register ops get their own state pair
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_DEC,
    S_LDI_T3, S_LDI_T4, S_ALU_T3, S_ALU_T4, S_T5,
    S_OUT_T3, S_IN_T3, S_HALT
  } state_e;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0..T2 (T1 held MEM_WAIT cycles), decode slot, execute T3..T5.
// Moore strobes from the state register; run/step_en gate the start of each fetch, clear aborts anywhere.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OPW      = 5,
  parameter int ALUW     = 4,
  parameter int BSW      = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic            step_en,
  input  logic [OPW-1:0]  ir_op,
  output logic            incPC,
  output logic            e_MAR,
  output logic            e_MDR,
  output logic            e_IR,
  output logic            e_Y,
  output logic            e_Z,
  output logic            e_Rin,
  output logic            e_Rout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            BAout,
  output logic            imm_sel,
  output logic            ram_read,
  output logic            MDR_read,
  output logic            e_OutPort,
  output logic            e_InPort,
  output logic [ALUW-1:0] ALU_op,
  output logic [BSW-1:0]  BusDataSelect,
  output logic            instr_done,
  output logic            halted,
  output logic            illegal
);

  if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("ctrl_sequencer: MEM_WAIT=%0d outside 1..15", MEM_WAIT);
  end
  if (OPW != OPW_C || ALUW != ALUW_C || BSW != BSW_C) begin : g_bad_width
    $error("ctrl_sequencer: field widths must match ctrl_sequencer_pkg encodings");
  end

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_e         state_q, state_d;
  logic [3:0]     wait_q, wait_d;
  logic [OPW-1:0] op_q, op_d;
  logic           illegal_q, illegal_d;
  logic           instr_end;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    instr_end = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_T1W;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end
      S_T1W:    state_d = S_T2;
      S_T2:     state_d = S_DEC;
      // IR was loaded at the edge ending T2, so ir_op is stable for the whole decode slot
      S_DEC: begin
        op_d = ir_op;
        case (ir_op)
          OP_LDI:                     state_d = S_LDI_T3;
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALU_T3;
          OP_OUT:                     state_d = S_OUT_T3;
          OP_IN:                      state_d = S_IN_T3;
          OP_NOP:                     instr_end = 1'b1;
          OP_HALT:                    state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_LDI_T3: state_d = S_LDI_T4;
      S_LDI_T4: state_d = S_T5;
      S_ALU_T3: state_d = S_ALU_T4;
      S_ALU_T4: state_d = S_T5;
      S_T5, S_OUT_T3, S_IN_T3: instr_end = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (instr_end) state_d = (run && !step_en) ? S_T0 : S_IDLE;
  end

  always_comb begin
    {incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z, e_Rin, e_Rout} = '0;
    {Gra, Grb, Grc, BAout, imm_sel}                    = '0;
    {ram_read, MDR_read, e_OutPort, e_InPort}          = '0;
    ALU_op        = ALU_NONE;
    BusDataSelect = BUS_GP;
    case (state_q)
      S_T0: begin
        BusDataSelect = BUS_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
      end
      S_T1:  ram_read = 1'b1;
      S_T1W: begin
        MDR_read = 1'b1;
        e_MDR    = 1'b1;
      end
      S_T2: begin
        BusDataSelect = BUS_MDR;
        e_IR          = 1'b1;
      end
      S_LDI_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        e_Y   = 1'b1;
      end
      S_LDI_T4: begin
        imm_sel = 1'b1;
        ALU_op  = ALU_ADD;
        e_Z     = 1'b1;
      end
      S_ALU_T3: begin
        Grb    = 1'b1;
        e_Rout = 1'b1;
        e_Y    = 1'b1;
      end
      S_ALU_T4: begin
        Grc    = 1'b1;
        e_Rout = 1'b1;
        ALU_op = alu_code(op_q);
        e_Z    = 1'b1;
      end
      S_T5: begin
        Gra           = 1'b1;
        e_Rin         = 1'b1;
        BusDataSelect = BUS_ZLO;
      end
      S_OUT_T3: begin
        Gra       = 1'b1;
        e_Rout    = 1'b1;
        e_OutPort = 1'b1;
      end
      S_IN_T3: begin
        BusDataSelect = BUS_INPORT;
        Gra           = 1'b1;
        e_Rin         = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_done = instr_end;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (MEM_WAIT 1 and 3) fed by a tiny fetch model,
// random programs expanded into expected strobe traces and checked by per-instance monitors.
module tb_ctrl_sequencer;

  localparam logic [4:0] LDI = 5'b00001, ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101,
                         OR_ = 5'b00110, IN_ = 5'b10110, OUT = 5'b10111, NOP = 5'b11010,
                         HLT = 5'b11011;
  localparam logic [4:0] B_ZLO = 5'b10011, B_PC = 5'b10100, B_MDR = 5'b10101, B_INP = 5'b10110;

  typedef struct packed {
    logic incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z, e_Rin, e_Rout;
    logic Gra, Grb, Grc, BAout, imm_sel, ram_read, MDR_read, e_OutPort, e_InPort;
    logic [3:0] alu;
    logic [4:0] bus;
    logic done;
  } cw_t;

  typedef struct packed {
    cw_t w;
    int  d;   // cycles since previous non-zero word, -1 = unchecked
  } ent_t;

  localparam int MWS [2] = '{1, 3};

  logic clk = 1'b0;
  logic clear, run, step_en;
  logic [4:0] prog [64];
  ent_t exp_q [2][$];
  cw_t  w_a [2];
  logic halted_a [2];
  logic illegal_a [2];
  logic idle_a [2];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar I = 0; I < 2; I++) begin : g_dut
    logic incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z, e_Rin, e_Rout, Gra, Grb, Grc, BAout, imm_sel;
    logic ram_read, MDR_read, e_OutPort, e_InPort, instr_done, halted, illegal;
    logic [3:0] ALU_op;
    logic [4:0] BusDataSelect;
    logic [4:0] ir_op;
    logic [5:0] pc, mar;

    ctrl_sequencer #(.MEM_WAIT(MWS[I])) dut (
      .clock(clk), .clear(clear), .run(run), .step_en(step_en), .ir_op(ir_op),
      .incPC(incPC), .e_MAR(e_MAR), .e_MDR(e_MDR), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z),
      .e_Rin(e_Rin), .e_Rout(e_Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
      .imm_sel(imm_sel), .ram_read(ram_read), .MDR_read(MDR_read), .e_OutPort(e_OutPort),
      .e_InPort(e_InPort), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
      .instr_done(instr_done), .halted(halted), .illegal(illegal)
    );

    assign w_a[I] = {incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z, e_Rin, e_Rout, Gra, Grb, Grc, BAout,
                     imm_sel, ram_read, MDR_read, e_OutPort, e_InPort, ALU_op, BusDataSelect,
                     instr_done};
    assign halted_a[I]  = halted;
    assign illegal_a[I] = illegal;
    assign idle_a[I]    = (dut.state_q == ctrl_sequencer_pkg::S_IDLE);

    // Minimal datapath: PC/MAR/IR just enough to hand opcodes back to the sequencer
    always @(posedge clk or posedge clear) begin
      if (clear) begin
        pc <= '0; mar <= '0; ir_op <= '0;
      end else begin
        if (incPC) pc <= pc + 6'd1;
        if (e_MAR) mar <= pc;
        if (e_IR)  ir_op <= prog[mar];
      end
    end

    initial begin : monitor
      int cyc, last;
      ent_t e;
      cyc = 0; last = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!clear && w_a[I] != '0) begin
          if (exp_q[I].size() == 0) begin
            total++; bad++;
            $display("FAIL dut%0d unexpected_word got=%h want=none", I, w_a[I]);
          end else begin
            e = exp_q[I].pop_front();
            total++;
            if (w_a[I] !== e.w) begin
              bad++;
              $display("FAIL dut%0d ctrl_word got=%h want=%h", I, w_a[I], e.w);
            end
            if (e.d >= 0) begin
              total++;
              if (cyc - last != e.d) begin
                bad++;
                $display("FAIL dut%0d word_gap got=%0d want=%0d", I, cyc - last, e.d);
              end
            end
          end
          last = cyc;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {LDI, ADD, SUB, AND_, OR_, IN_, OUT, NOP, HLT};
  endfunction

  function automatic logic [4:0] rand_op();
    logic [4:0] ops [8];
    ops = '{LDI, ADD, SUB, AND_, OR_, IN_, OUT, NOP};
    return ops[$urandom_range(0, 7)];
  endfunction

  function automatic void put(input int k, input cw_t c, inout int d);
    exp_q[k].push_back('{c, d});
    d = 1;
  endfunction

  // Expand one instruction into the non-zero control words it must produce
  task automatic push_instr(input int k, input logic [4:0] op, input int d0);
    cw_t c;
    int d;
    d = d0;
    c = '0; c.bus = B_PC; c.e_MAR = 1; c.incPC = 1; put(k, c, d);
    for (int n = 0; n < MWS[k]; n++) begin
      c = '0; c.ram_read = 1; put(k, c, d);
    end
    c = '0; c.MDR_read = 1; c.e_MDR = 1; put(k, c, d);
    c = '0; c.bus = B_MDR; c.e_IR = 1; put(k, c, d);
    if (op == NOP) begin
      c = '0; c.done = 1; put(k, c, d);
      return;
    end
    d = 2;
    case (op)
      LDI: begin
        c = '0; c.Grb = 1; c.BAout = 1; c.e_Y = 1; put(k, c, d);
        c = '0; c.imm_sel = 1; c.alu = 4'b0011; c.e_Z = 1; put(k, c, d);
        c = '0; c.Gra = 1; c.e_Rin = 1; c.bus = B_ZLO; c.done = 1; put(k, c, d);
      end
      ADD, SUB, AND_, OR_: begin
        c = '0; c.Grb = 1; c.e_Rout = 1; c.e_Y = 1; put(k, c, d);
        c = '0; c.Grc = 1; c.e_Rout = 1; c.e_Z = 1;
        c.alu = (op == ADD) ? 4'b0011 : (op == SUB) ? 4'b0100 : (op == AND_) ? 4'b0101 : 4'b0110;
        put(k, c, d);
        c = '0; c.Gra = 1; c.e_Rin = 1; c.bus = B_ZLO; c.done = 1; put(k, c, d);
      end
      OUT: begin
        c = '0; c.Gra = 1; c.e_Rout = 1; c.e_OutPort = 1; c.done = 1; put(k, c, d);
      end
      IN_: begin
        c = '0; c.bus = B_INP; c.Gra = 1; c.e_Rin = 1; c.done = 1; put(k, c, d);
      end
      default: ;
    endcase
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, exp_q[0].size() + exp_q[1].size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic restart();
    @(posedge clk); #1;
    clear = 1; run = 0; step_en = 0;
    exp_q[0].delete(); exp_q[1].delete();
    @(posedge clk); #1;
  endtask

  task automatic load_random();
    for (int i = 0; i < 64; i++) prog[i] = rand_op();
  endtask

  initial begin
    logic [4:0] bad_op;
    bit got;
    clear = 1; run = 0; step_en = 0;
    load_random();
    #20;
    for (int k = 0; k < 2; k++) begin
      chk("reset_word", w_a[k], 0);
      chk("reset_halted", halted_a[k], 0);
      chk("reset_idle", idle_a[k], 1);
    end
    #30 clear = 0;
    repeat (5) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("idle_no_run_word", w_a[k], 0);
      chk("idle_no_run_illegal", illegal_a[k], 0);
      chk("idle_no_run_state", idle_a[k], 1);
    end

    // free-running program: ldi, out, random ops, halt
    restart();
    prog[0] = LDI; prog[1] = OUT; prog[8] = HLT;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 9; i++) push_instr(k, prog[i], (i == 0) ? -1 : 1);
    clear = 0; run = 1;
    drain("run", 400);
    for (int k = 0; k < 2; k++) begin
      chk("run_halted", halted_a[k], 1);
      chk("run_illegal", illegal_a[k], 0);
    end

    // step mode with run held: one idle cycle between instructions
    restart();
    load_random();
    prog[6] = HLT;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 7; i++) push_instr(k, prog[i], (i == 0) ? -1 : 2);
    clear = 0; run = 1; step_en = 1;
    drain("step", 400);
    for (int k = 0; k < 2; k++) chk("step_halted", halted_a[k], 1);

    // one-cycle run pulses: each pulse must advance exactly one instruction
    restart();
    load_random();
    clear = 0;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 2; k++) push_instr(k, prog[p], -1);
      step_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1 run = 1;
      @(posedge clk); #1 run = 0;
      repeat (20) @(negedge clk);
      chk("pulse_queue_empty", exp_q[0].size() + exp_q[1].size(), 0);
      for (int k = 0; k < 2; k++) chk("pulse_idle", idle_a[k], 1);
    end

    // illegal opcode traps into halt
    restart();
    load_random();
    bad_op = 5'b11111;
    prog[3] = bad_op;
    bad_op = 5'($urandom_range(0, 31));
    while (is_legal(bad_op)) bad_op = 5'($urandom_range(0, 31));
    prog[4] = bad_op;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push_instr(k, prog[i], (i == 0) ? -1 : 1);
    clear = 0; run = 1;
    drain("illegal", 400);
    for (int k = 0; k < 2; k++) begin
      chk("illegal_flag", illegal_a[k], 1);
      chk("illegal_halted", halted_a[k], 1);
    end
    restart();
    clear = 0; run = 0;
    for (int k = 0; k < 2; k++) begin
      chk("illegal_cleared", illegal_a[k], 0);
      chk("halt_cleared", halted_a[k], 0);
    end
    restart();
    prog[0] = bad_op;
    for (int k = 0; k < 2; k++) push_instr(k, prog[0], -1);
    clear = 0; run = 1;
    drain("illegal_rand", 100);
    chk("illegal_rand_flag", illegal_a[0], 1);

    // abort with clear while the MEM_WAIT=1 instance sits in T4
    restart();
    load_random();
    prog[0] = ADD;
    for (int k = 0; k < 2; k++) begin
      push_instr(k, prog[0], -1);
      push_instr(k, prog[1], 1);
    end
    clear = 0; run = 1;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      if (w_a[0].alu != 4'b0000) got = 1;
    end
    chk("reached_t4", got, 1);
    clear = 1;
    #1;
    exp_q[0].delete(); exp_q[1].delete();
    run = 0;
    for (int k = 0; k < 2; k++) begin
      chk("abort_word", w_a[k], 0);
      chk("abort_idle", idle_a[k], 1);
    end
    @(negedge clk); #2 clear = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("abort_stays_idle", w_a[k], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
